complex_row_by_vector_pipe: RTL and testbench

Parametrised, fully pipelined fixed-point complex row-by-vector dot-product engine. Computes the dot product of one matrix row and the search vector, delivered as num_chunks chunks of LANES complex pairs. It accumulates across chunks in one internal accumulator and emits a single complex result with a valid pulse. It is the next-generation replacement for the fixed 3-lane float row engine, feeding the decoder stage.

---
 rtl/complex_rbv_pkg.sv | 28 ++
 rtl/complex_row_by_vector_pipe_mult.sv | 38 +++
 rtl/complex_row_by_vector_pipe.sv | 158 +++++++++++++++
 tb/tb_complex_row_by_vector_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_rbv_pkg.sv
// complex_rbv_pkg: widths, FSM encoding and round/saturate helper shared by the complex row-by-vector engine
package complex_rbv_pkg;
  localparam int MAXW = 128;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
  function automatic int prod_w(input int dw);
    return 2 * dw + 1;
  endfunction
  function automatic int tree_w(input int dw, input int lanes);
    return prod_w(dw) + clog2(lanes);
  endfunction
  function automatic int acc_w(input int dw, input int lanes, input int guard);
    return tree_w(dw, lanes) + guard;
  endfunction
  function automatic logic [MAXW:0] sat_round(input logic signed [MAXW-1:0] s, input int dw, input int frac);
    logic signed [MAXW-1:0] one, r, hi, lo;
    one = MAXW'(1);
    r = (s + (one <<< (frac - 1))) >>> frac;
    hi = (one <<< (dw - 1)) - one;
    lo = -(one <<< (dw - 1));
    return (r > hi) ? {1'b1, hi} : (r < lo) ? {1'b1, lo} : {1'b0, r};
  endfunction
endpackage

// File: rtl/complex_row_by_vector_pipe_mult.sv
// complex_mult_fx: one-lane registered complex multiply; in: clk, reset, in_valid, a/p {re,im}; out: out_valid, full-precision re/im
module complex_mult_fx #(
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [2*DW-1:0]   a,
  input  logic [2*DW-1:0]   p,
  output logic              out_valid,
  output logic signed [2*DW:0] re,
  output logic signed [2*DW:0] im
);
  localparam int PW = 2 * DW + 1;
  logic signed [PW-1:0] ar, ai, pr, pi, re_d, im_d, re_q, im_q;
  logic valid_q;
  always_comb begin
    ar = PW'($signed(a[2*DW-1:DW]));
    ai = PW'($signed(a[DW-1:0]));
    pr = PW'($signed(p[2*DW-1:DW]));
    pi = PW'($signed(p[DW-1:0]));
    re_d = ar * pr - ai * pi;
    im_d = ar * pi + ai * pr;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid_q <= 1'b0;
      re_q <= '0;
      im_q <= '0;
    end else begin
      valid_q <= in_valid;
      re_q <= re_d;
      im_q <= im_d;
    end
  assign out_valid = valid_q;
  assign re = re_q;
  assign im = im_q;
endmodule

// File: rtl/complex_row_by_vector_pipe.sv
// complex_row_by_vector_pipe: pipelined complex row.vector dot product over num_chunks chunks; in: clk, reset, start, num_chunks, a_in, p_in, in_valid; out: in_ready, result, result_valid, result_sat, busy
module complex_row_by_vector_pipe
  import complex_rbv_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int DW        = 32,
  parameter int FRAC      = 16,
  parameter int MAXCH_W   = 8,
  parameter int ACC_GUARD = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [MAXCH_W-1:0]      num_chunks,
  input  logic [LANES*2*DW-1:0]   a_in,
  input  logic [LANES*2*DW-1:0]   p_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [2*DW-1:0]         result,
  output logic                    result_valid,
  output logic                    result_sat,
  output logic                    busy
);
  localparam int LG = clog2(LANES);
  localparam int PW = prod_w(DW);
  localparam int TW = tree_w(DW, LANES);
  localparam int AW = acc_w(DW, LANES, ACC_GUARD);
  state_t state_q, state_d;
  logic [MAXCH_W-1:0] cnt_q, cnt_d, nch_q, nch_d;
  logic take, first_in, last_in;
  logic [LANES-1:0] mv;
  logic signed [PW-1:0] mre [LANES];
  logic signed [PW-1:0] mim [LANES];
  logic signed [TW-1:0] hre [1:2*LANES-1];
  logic signed [TW-1:0] him [1:2*LANES-1];
  logic signed [TW-1:0] tre_q [1:LANES-1];
  logic signed [TW-1:0] tim_q [1:LANES-1];
  logic signed [TW-1:0] tre_d [1:LANES-1];
  logic signed [TW-1:0] tim_d [1:LANES-1];
  logic [LG:0] f_q, f_d, l_q, l_d;
  logic [LG:1] v_q, v_d;
  logic vo, fo, lo;
  logic signed [AW-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d, sre, sim;
  logic [MAXW:0] rr, ri;
  logic [2*DW-1:0] res_q, res_d;
  logic rv_q, rv_d, sat_q, sat_d;
  logic unused_bits;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    complex_mult_fx #(.DW(DW)) u_mult (
      .clk      (clk),
      .reset    (reset),
      .in_valid (take),
      .a        (a_in[i*2*DW +: 2*DW]),
      .p        (p_in[i*2*DW +: 2*DW]),
      .out_valid(mv[i]),
      .re       (mre[i]),
      .im       (mim[i])
    );
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    nch_d = nch_q;
    take = (state_q == RUN) && in_valid;
    first_in = take && (cnt_q == '0);
    last_in = take && ((cnt_q + MAXCH_W'(1)) == nch_q);
    case (state_q)
      IDLE: if (start && num_chunks != '0) begin
        state_d = RUN;
        nch_d = num_chunks;
        cnt_d = '0;
      end
      RUN: if (take) begin
        cnt_d = cnt_q + MAXCH_W'(1);
        state_d = last_in ? DRAIN : RUN;
      end
      DRAIN: state_d = rv_q ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // heap layout: leaves LANES..2*LANES-1 are the multiplier registers, node i sums nodes 2i and 2i+1
  always_comb begin
    for (int k = 1; k < LANES; k++) begin
      hre[k] = tre_q[k];
      him[k] = tim_q[k];
    end
    for (int k = 0; k < LANES; k++) begin
      hre[LANES+k] = TW'(mre[k]);
      him[LANES+k] = TW'(mim[k]);
    end
    for (int k = 1; k < LANES; k++) begin
      tre_d[k] = hre[2*k] + hre[2*k+1];
      tim_d[k] = him[2*k] + him[2*k+1];
    end
    f_d[0] = first_in;
    l_d[0] = last_in;
    v_d[1] = &mv;
    for (int k = 1; k <= LG; k++) begin
      f_d[k] = f_q[k-1];
      l_d[k] = l_q[k-1];
    end
    for (int k = 2; k <= LG; k++) v_d[k] = v_q[k-1];
  end
  always_comb begin
    vo = v_q[LG];
    fo = f_q[LG];
    lo = l_q[LG];
    sre = AW'(tre_q[1]) + (fo ? AW'(0) : acc_re_q);
    sim = AW'(tim_q[1]) + (fo ? AW'(0) : acc_im_q);
    acc_re_d = vo ? sre : acc_re_q;
    acc_im_d = vo ? sim : acc_im_q;
    rr = sat_round(MAXW'(sre), DW, FRAC);
    ri = sat_round(MAXW'(sim), DW, FRAC);
    rv_d = vo && lo;
    res_d = rv_d ? {rr[DW-1:0], ri[DW-1:0]} : res_q;
    sat_d = rv_d ? (rr[MAXW] | ri[MAXW]) : sat_q;
    unused_bits = ^{rr[MAXW-1:DW], ri[MAXW-1:DW]};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      nch_q <= '0;
      for (int k = 1; k < LANES; k++) begin
        tre_q[k] <= '0;
        tim_q[k] <= '0;
      end
      f_q <= '0;
      l_q <= '0;
      v_q <= '0;
      acc_re_q <= '0;
      acc_im_q <= '0;
      res_q <= '0;
      rv_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      nch_q <= nch_d;
      for (int k = 1; k < LANES; k++) begin
        tre_q[k] <= tre_d[k];
        tim_q[k] <= tim_d[k];
      end
      f_q <= f_d;
      l_q <= l_d;
      v_q <= v_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      res_q <= res_d;
      rv_q <= rv_d;
      sat_q <= sat_d;
    end
  assign in_ready = state_q == RUN;
  assign busy = state_q != IDLE;
  assign result = res_q;
  assign result_valid = rv_q;
  assign result_sat = sat_q;
endmodule

// File: tb/tb_complex_row_by_vector_pipe.sv
// tb_complex_row_by_vector_pipe: directed vectors against a row-level arithmetic model plus literal pins
module tb_complex_row_by_vector_pipe;
  localparam int LANES = 4, DW = 32, FRAC = 16, MAXCH_W = 8, ACC_GUARD = 8;
  localparam int CW = LANES * 2 * DW;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [MAXCH_W-1:0] num_chunks = '0;
  logic [CW-1:0] a_in = '0, p_in = '0;
  logic in_ready, result_valid, result_sat, busy;
  logic [2*DW-1:0] result;
  complex_row_by_vector_pipe #(
    .LANES(LANES), .DW(DW), .FRAC(FRAC), .MAXCH_W(MAXCH_W), .ACC_GUARD(ACC_GUARD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_chunks(num_chunks),
    .a_in(a_in), .p_in(p_in), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .result_valid(result_valid), .result_sat(result_sat), .busy(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int errs = 0, checks = 0;
  logic [CW-1:0] ach [8];
  logic [CW-1:0] pch [8];
  int bub [8];
  typedef struct {int due; logic [2*DW-1:0] res; logic sat;} exp_t;
  exp_t q [$];
  logic [2*DW-1:0] last_res = '0;
  logic last_sat = 1'b0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  function automatic logic signed [127:0] sx(input logic [DW-1:0] v);
    return {{(128-DW){v[DW-1]}}, v};
  endfunction
  function automatic logic [DW:0] rnd(input logic signed [127:0] s);
    logic signed [127:0] r, mx, mn;
    r = (s + (128'sd1 <<< (FRAC - 1))) >>> FRAC;
    mx = (128'sd1 <<< (DW - 1)) - 128'sd1;
    mn = -mx - 128'sd1;
    if (r > mx) return {1'b1, mx[DW-1:0]};
    if (r < mn) return {1'b1, mn[DW-1:0]};
    return {1'b0, r[DW-1:0]};
  endfunction
  function automatic logic [2*DW:0] model(input int n);
    logic signed [127:0] sr, si, ar, ai, pr, pi;
    logic [DW:0] rr, ri;
    sr = 0;
    si = 0;
    for (int c = 0; c < n; c++)
      for (int l = 0; l < LANES; l++) begin
        ar = sx(ach[c][l*2*DW+DW +: DW]);
        ai = sx(ach[c][l*2*DW +: DW]);
        pr = sx(pch[c][l*2*DW+DW +: DW]);
        pi = sx(pch[c][l*2*DW +: DW]);
        sr += ar * pr - ai * pi;
        si += ar * pi + ai * pr;
      end
    rr = rnd(sr);
    ri = rnd(si);
    return {rr[DW] | ri[DW], rr[DW-1:0], ri[DW-1:0]};
  endfunction
  task automatic set_chunk(input int c, input logic [DW-1:0] ar, input logic [DW-1:0] ai,
                           input logic [DW-1:0] pr, input logic [DW-1:0] pi, input bit all);
    ach[c] = '0;
    pch[c] = '0;
    for (int l = 0; l < LANES; l++)
      if (all || l == 0) begin
        ach[c][l*2*DW +: 2*DW] = {ar, ai};
        pch[c][l*2*DW +: 2*DW] = {pr, pi};
      end
  endtask
  // entered and left at a falling edge; inj marks a chunk that also carries a start pulse
  task automatic run_row(input int n, input int inj);
    logic [2*DW:0] e;
    int k;
    e = model(n);
    start = 1'b1;
    num_chunks = MAXCH_W'(n);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_run", in_ready, 1);
    for (int c = 0; c < n; c++) begin
      repeat (bub[c]) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      a_in = ach[c];
      p_in = pch[c];
      if (c == inj) begin
        start = 1'b1;
        num_chunks = 8'd5;
      end
      if (c == n - 1) q.push_back('{due: cyc + 4, res: e[2*DW-1:0], sat: e[2*DW]});
      @(negedge clk);
      start = 1'b0;
    end
    in_valid = 1'b0;
    a_in = '0;
    p_in = '0;
    chk("in_ready_drain", in_ready, 0);
    k = 0;
    while (!result_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("row_done", result_valid, 1);
    chk("busy_at_valid", busy, 1);
    @(negedge clk);
    chk("busy_after_valid", busy, 0);
    chk("valid_one_cycle", result_valid, 0);
  endtask
  always @(negedge clk)
    if (!reset) begin
      if (result_valid) begin
        if (q.size() == 0 || q[0].due != cyc) begin
          checks++;
          errs++;
          $display("FAIL unexpected_valid: result_valid=1 at cycle %0d, required 0", cyc);
        end else begin
          chk("result", result, q[0].res);
          chk("result_sat", result_sat, q[0].sat);
          void'(q.pop_front());
        end
        last_res = result;
        last_sat = result_sat;
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        checks++;
        errs++;
        $display("FAIL missing_valid: result_valid=0 at cycle %0d, required 1", cyc);
        void'(q.pop_front());
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end
  initial begin
    logic [2*DW:0] e;
    int seen;
    for (int i = 0; i < 8; i++) bub[i] = 0;
    #1 reset = 1'b1;
    #2;
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_sat", result_sat, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    set_chunk(0, 32'h00010000, 32'h0, 32'h00020000, 32'h00030000, 1);
    e = model(1);
    chk("model_t1", e, {1'b0, 64'h00080000_000C0000});
    run_row(1, -1);
    chk("t1_result", last_res, 64'h00080000_000C0000);
    chk("t1_sat", last_sat, 0);
    for (int c = 0; c < 3; c++) set_chunk(c, 32'h0, 32'h00010000, 32'h00010000, 32'h0, 1);
    bub[0] = 0; bub[1] = 2; bub[2] = 1;
    e = model(3);
    chk("model_t2", e, {1'b0, 64'h00000000_000C0000});
    run_row(3, -1);
    chk("t2_result", last_res, 64'h00000000_000C0000);
    bub[1] = 0; bub[2] = 0;
    set_chunk(0, 32'h00010000, 32'h00020000, 32'h00030000, 32'hFFFC0000, 0);
    e = model(1);
    chk("model_t3", e, {1'b0, 64'h000B0000_00020000});
    run_row(1, -1);
    chk("t3_result", last_res, 64'h000B0000_00020000);
    set_chunk(0, 32'h00008000, 32'h0, 32'h00000001, 32'h0, 0);
    e = model(1);
    chk("model_half_lsb", e, {1'b0, 64'h00000001_00000000});
    run_row(1, -1);
    chk("half_lsb_result", last_res, 64'h00000001_00000000);
    set_chunk(0, 32'h00007FFF, 32'h0, 32'h00000001, 32'h0, 0);
    run_row(1, -1);
    chk("below_half_result", last_res, 64'h0);
    set_chunk(0, 32'h7FFF0000, 32'h0, 32'h7FFF0000, 32'h0, 1);
    e = model(1);
    chk("model_sat_pos", e, {1'b1, 64'h7FFFFFFF_00000000});
    run_row(1, -1);
    chk("sat_pos_result", last_res, 64'h7FFFFFFF_00000000);
    chk("sat_pos_flag", last_sat, 1);
    set_chunk(0, 32'h80010000, 32'h0, 32'h7FFF0000, 32'h0, 1);
    run_row(1, -1);
    chk("sat_neg_result", last_res, 64'h80000000_00000000);
    chk("sat_neg_flag", last_sat, 1);
    start = 1'b1;
    num_chunks = '0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_chunks_busy", busy, 0);
    chk("zero_chunks_ready", in_ready, 0);
    @(negedge clk);
    chk("zero_chunks_busy2", busy, 0);
    set_chunk(0, 32'h00010000, 32'h0, 32'h00020000, 32'h00030000, 1);
    set_chunk(1, 32'h00010000, 32'h0, 32'h00020000, 32'h00030000, 1);
    run_row(2, 0);
    chk("start_in_run_result", last_res, 64'h00100000_00180000);
    set_chunk(2, 32'h00010000, 32'h0, 32'h00020000, 32'h00030000, 1);
    start = 1'b1;
    num_chunks = 8'd3;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1;
      a_in = ach[c];
      p_in = pch[c];
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    chk("midrun_reset_ready", in_ready, 0);
    chk("midrun_reset_busy", busy, 0);
    chk("midrun_reset_valid", result_valid, 0);
    chk("midrun_reset_result", result, 0);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (result_valid) seen++;
    end
    chk("no_valid_after_reset", seen, 0);
    set_chunk(0, 32'h00010000, 32'h00020000, 32'h00030000, 32'hFFFC0000, 0);
    run_row(1, -1);
    chk("after_reset_result", last_res, 64'h000B0000_00020000);
    set_chunk(0, 32'h7FFF0000, 32'h0, 32'h7FFF0000, 32'h0, 1);
    run_row(1, -1);
    set_chunk(0, 32'h0, 32'h00010000, 32'h00010000, 32'h0, 1);
    e = model(1);
    chk("model_b2b", e, {1'b0, 64'h00000000_00040000});
    run_row(1, -1);
    chk("b2b_result", last_res, 64'h00000000_00040000);
    chk("b2b_sat", last_sat, 0);
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
